// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline stages.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fft_pkg;

    localparam int FFT_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sdf_state_e;

    // Ceiling log2 with a floor of 1 so that a 1-sample stage still gets a 1-bit counter
    function automatic int sdf_clog2(input int n);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < n) begin
                r = b + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sdf_delay_ctrl.sv
// Sequencing for one SDF delay line: IDLE/RUN/DRAIN FSM, drain counter and phase counter.
// Latency: state and counters update on the edge that consumes in_valid; shift_en is combinational.
// Backpressure: none; the line always advances when input is present or it still holds data.
module sdf_delay_ctrl
    import fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             tail_empty,
    output logic             shift_en,
    output logic             busy,
    output logic             bf_sel,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(2 * DEPTH - 1);

    sdf_state_e       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            phase_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            phase_cnt_q <= phase_cnt_d;
        end
    end

    // Next state: a missing sample starts a drain; the drain ends once the line has
    // emptied itself (tail_empty means this zero-shift clears the last valid slot)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (!in_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (in_valid) begin
                    state_d = RUN;
                end else if (tail_empty || (drain_cnt_q == DRAIN_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain length and butterfly phase; phase restarts from 0 whenever the stage goes idle
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        phase_cnt_d = phase_cnt_q;
        if (state_q == RUN && !in_valid) begin
            drain_cnt_d = '0;
        end else if (state_q == DRAIN) begin
            drain_cnt_d = in_valid ? '0 : drain_cnt_q + 1'b1;
        end
        if (state_d == IDLE) begin
            phase_cnt_d = '0;
        end else if (shift_en) begin
            phase_cnt_d = (phase_cnt_q == PHASE_LAST) ? '0 : phase_cnt_q + 1'b1;
        end
    end

    // Outputs: outside IDLE every cycle shifts, so a gap pushes a zero instead of stalling
    always_comb begin
        shift_en  = in_valid | (state_q != IDLE);
        busy      = (state_q != IDLE);
        bf_sel    = phase_cnt_q[CNT_W-1];
        phase_cnt = phase_cnt_q;
    end

endmodule

// File: rtl/sdf_delay_line.sv
// Complex-sample delay line of DEPTH accepted samples for one SDF FFT stage, with valid tags.
// Latency: DEPTH shift edges from the edge that accepts a sample to it appearing on dout.
// Backpressure: none; input is never refused and gaps advance the line with zero slots.
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter  int DATA_W = FFT_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = sdf_clog2(2 * DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         phase_cnt,
    output logic                     bf_sel,
    output logic                     busy
);

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    logic             shift_en;
    logic             tail_empty;
    logic [DEPTH-1:0] vtag_vec;
    cplx_t            head_dat;
    cplx_t            tail_dat;

    // Head of the line: a cycle without input enters as an all-zero slot
    always_comb begin
        head_dat = '0;
        if (in_valid) begin
            head_dat.re = din_r;
            head_dat.im = din_i;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        cplx_t slot_d, slot_q;
        logic  vtag_d, vtag_q;
        cplx_t src_dat;
        logic  src_vld;

        if (k == 0) begin : g_head
            assign src_dat = head_dat;
            assign src_vld = in_valid;
        end else begin : g_body
            assign src_dat = g_slot[k-1].slot_q;
            assign src_vld = g_slot[k-1].vtag_q;
        end

        // Move one position on every shift event, hold otherwise
        always_comb begin
            slot_d = slot_q;
            vtag_d = vtag_q;
            if (shift_en) begin
                slot_d = src_dat;
                vtag_d = src_vld;
            end
        end

        // Slot storage; reset discards everything in flight
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
                vtag_q <= 1'b0;
            end else begin
                slot_q <= slot_d;
                vtag_q <= vtag_d;
            end
        end

        assign vtag_vec[k] = vtag_q;
    end

    // The next zero-shift empties the line when no slot ahead of the tail is valid
    if (DEPTH > 1) begin : g_tail
        assign tail_empty = ~|vtag_vec[DEPTH-2:0];
    end else begin : g_tail_single
        assign tail_empty = 1'b1;
    end

    sdf_delay_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .tail_empty (tail_empty),
        .shift_en   (shift_en),
        .busy       (busy),
        .bf_sel     (bf_sel),
        .phase_cnt  (phase_cnt)
    );

    assign tail_dat  = g_slot[DEPTH-1].slot_q;
    assign dout_r    = tail_dat.re;
    assign dout_i    = tail_dat.im;
    assign out_valid = vtag_vec[DEPTH-1];

endmodule

// File: tb/tb_sdf_delay_line.sv
// Self-checking bench for sdf_delay_line at DEPTH 16, 1 and 32.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdf_delay_line;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // DEPTH=16, DATA_W=24
    logic               a_v, a_ov, a_bf, a_busy;
    logic signed [23:0] a_r, a_i, a_dr, a_di;
    logic [4:0]         a_ph;
    // DEPTH=1, DATA_W=16
    logic               b_v, b_ov, b_bf, b_busy;
    logic signed [15:0] b_r, b_i, b_dr, b_di;
    logic [0:0]         b_ph;
    // DEPTH=32, DATA_W=24
    logic               c_v, c_ov, c_bf, c_busy;
    logic signed [23:0] c_r, c_i, c_dr, c_di;
    logic [5:0]         c_ph;

    sdf_delay_line #(.DATA_W(24), .DEPTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_v), .din_r(a_r), .din_i(a_i),
        .dout_r(a_dr), .dout_i(a_di), .out_valid(a_ov), .phase_cnt(a_ph), .bf_sel(a_bf), .busy(a_busy));

    sdf_delay_line #(.DATA_W(16), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_v), .din_r(b_r), .din_i(b_i),
        .dout_r(b_dr), .dout_i(b_di), .out_valid(b_ov), .phase_cnt(b_ph), .bf_sel(b_bf), .busy(b_busy));

    sdf_delay_line #(.DATA_W(24), .DEPTH(32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_v), .din_r(c_r), .din_i(c_i),
        .dout_r(c_dr), .dout_i(c_di), .out_valid(c_ov), .phase_cnt(c_ph), .bf_sel(c_bf), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        a_v = 1'b0; a_r = '0; a_i = '0;
        b_v = 1'b0; b_r = '0; b_i = '0;
        c_v = 1'b0; c_r = '0; c_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total++;
        if (a_dr !== 24'sd0 || a_di !== 24'sd0 || a_ov !== 1'b0) begin
            bad++; $display("FAIL reset_d16_data: got r=%0d i=%0d v=%0b want 0 0 0", a_dr, a_di, a_ov);
        end
        total++;
        if (a_ph !== 5'd0 || a_bf !== 1'b0 || a_busy !== 1'b0) begin
            bad++; $display("FAIL reset_d16_ctrl: got ph=%0d bf=%0b busy=%0b want 0 0 0", a_ph, a_bf, a_busy);
        end
        total++;
        if (b_dr !== 16'sd0 || b_ov !== 1'b0 || b_ph !== 1'b0 || b_busy !== 1'b0) begin
            bad++; $display("FAIL reset_d1: got r=%0d v=%0b ph=%0d busy=%0b want all 0", b_dr, b_ov, b_ph, b_busy);
        end
        total++;
        if (c_dr !== 24'sd0 || c_ov !== 1'b0 || c_ph !== 6'd0 || c_busy !== 1'b0) begin
            bad++; $display("FAIL reset_d32: got r=%0d v=%0b ph=%0d busy=%0b want all 0", c_dr, c_ov, c_ph, c_busy);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // 32 back-to-back samples r=k, i=-k
    task automatic test_back_to_back();
        int exp_ph;
        do_reset();
        for (int e = 1; e <= 34; e++) begin
            a_v = (e <= 32);
            a_r = (e <= 32) ? 24'(e - 1) : '0;
            a_i = (e <= 32) ? 24'(1 - e) : '0;
            @(posedge clk); #1;
            exp_ph = e % 32;
            total++;
            if (a_ov !== (e >= 16) || a_dr !== ((e >= 16) ? 24'(e - 16) : 24'd0) ||
                a_di !== ((e >= 16) ? 24'(16 - e) : 24'd0)) begin
                bad++; $display("FAIL b2b_data e=%0d: got v=%0b r=%0d i=%0d want v=%0b r=%0d", e, a_ov, a_dr, a_di,
                                (e >= 16), (e >= 16) ? e - 16 : 0);
            end
            if (e <= 32) begin
                total++;
                if (a_ph !== 5'(exp_ph) || a_bf !== (exp_ph >= 16)) begin
                    bad++; $display("FAIL b2b_phase e=%0d: got ph=%0d bf=%0b want ph=%0d bf=%0b", e, a_ph, a_bf,
                                    exp_ph, (exp_ph >= 16));
                end
            end
        end
    endtask

    // 20 samples then stop: tail 4..19 drains out, busy falls with out_valid
    task automatic test_drain();
        int idx;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            a_v = (e <= 20);
            a_r = (e <= 20) ? 24'(e - 1) : '0;
            a_i = (e <= 20) ? 24'(1 - e) : '0;
            @(posedge clk); #1;
            idx = e - 16;
            if (e >= 16) begin
                total++;
                if (idx <= 19) begin
                    if (a_ov !== 1'b1 || a_dr !== 24'(idx) || a_di !== 24'(-idx)) begin
                        bad++; $display("FAIL drain_data e=%0d: got v=%0b r=%0d i=%0d want v=1 r=%0d", e, a_ov, a_dr, a_di, idx);
                    end
                end else if (a_ov !== 1'b0 || a_dr !== 24'sd0 || a_di !== 24'sd0) begin
                    bad++; $display("FAIL drain_empty e=%0d: got v=%0b r=%0d i=%0d want 0 0 0", e, a_ov, a_dr, a_di);
                end
                total++;
                if (a_busy !== (e < 36)) begin
                    bad++; $display("FAIL drain_busy e=%0d: got %0b want %0b", e, a_busy, (e < 36));
                end
            end
        end
        total++;
        if (a_ph !== 5'd0) begin
            bad++; $display("FAIL drain_phase_idle: got %0d want 0", a_ph);
        end
    endtask

    // Stop after sample 9, three empty cycles, then resume
    task automatic test_gap();
        int nval_low;
        int nbusy_low;
        int src;
        do_reset();
        nval_low  = 0;
        nbusy_low = 0;
        for (int e = 1; e <= 40; e++) begin
            if (e <= 10) begin
                a_v = 1'b1; a_r = 24'(e - 1);
            end else if (e <= 13) begin
                a_v = 1'b0; a_r = '0;
            end else if (e <= 33) begin
                a_v = 1'b1; a_r = 24'(e - 4);
            end else begin
                a_v = 1'b0; a_r = '0;
            end
            a_i = -a_r;
            @(posedge clk); #1;
            if (a_busy !== 1'b1) nbusy_low++;
            if (e >= 16) begin
                src = e - 15;
                if (a_ov === 1'b0) nval_low++;
                total++;
                if (src >= 11 && src <= 13) begin
                    if (a_ov !== 1'b0 || a_dr !== 24'sd0) begin
                        bad++; $display("FAIL gap_bubble e=%0d: got v=%0b r=%0d want 0 0", e, a_ov, a_dr);
                    end
                end else if (a_ov !== 1'b1 || a_dr !== ((src <= 10) ? 24'(src - 1) : 24'(src - 4))) begin
                    bad++; $display("FAIL gap_order e=%0d: got v=%0b r=%0d want v=1 r=%0d", e, a_ov, a_dr,
                                    (src <= 10) ? src - 1 : src - 4);
                end
            end
        end
        total++;
        if (nval_low != 3) begin
            bad++; $display("FAIL gap_bubble_count: got %0d want 3", nval_low);
        end
        total++;
        if (nbusy_low != 0) begin
            bad++; $display("FAIL gap_busy: busy low on %0d edges want 0", nbusy_low);
        end
    endtask

    // Asynchronous reset between edges, then a clean restart
    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            a_v = 1'b1; a_r = 24'(e + 500); a_i = 24'(e + 900);
            @(posedge clk); #1;
        end
        total++;
        if (a_ov !== 1'b1 || a_busy !== 1'b1) begin
            bad++; $display("FAIL arst_pre: got v=%0b busy=%0b want 1 1", a_ov, a_busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (a_dr !== 24'sd0 || a_di !== 24'sd0 || a_ov !== 1'b0 || a_ph !== 5'd0 || a_bf !== 1'b0 || a_busy !== 1'b0) begin
            bad++; $display("FAIL arst_immediate: got r=%0d i=%0d v=%0b ph=%0d bf=%0b busy=%0b want all 0",
                            a_dr, a_di, a_ov, a_ph, a_bf, a_busy);
        end
        a_v = 1'b0;
        @(posedge clk); #4;
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            a_v = 1'b1; a_r = 24'(e + 99); a_i = 24'(-(e + 99));
            @(posedge clk); #1;
            total++;
            if (a_ov !== (e >= 16) || a_dr !== ((e >= 16) ? 24'(e + 84) : 24'd0)) begin
                bad++; $display("FAIL arst_restart e=%0d: got v=%0b r=%0d want v=%0b r=%0d", e, a_ov, a_dr,
                                (e >= 16), (e >= 16) ? e + 84 : 0);
            end
        end
        a_v = 1'b0;
    endtask

    // DEPTH=1: one-edge delay, phase alternates 1/0, most negative value passes unchanged
    task automatic test_depth1();
        logic [15:0] val;
        int          waited;
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            val = (e == 1) ? 16'h8000 : 16'($urandom);
            b_v = 1'b1; b_r = val; b_i = ~val;
            @(posedge clk); #1;
            total++;
            if (b_ov !== 1'b1 || b_dr !== val || b_di !== ~val) begin
                bad++; $display("FAIL d1_data e=%0d: got v=%0b r=%h i=%h want v=1 r=%h i=%h", e, b_ov, b_dr, b_di, val, ~val);
            end
            total++;
            if (b_ph !== 1'(e % 2) || b_bf !== 1'(e % 2)) begin
                bad++; $display("FAIL d1_phase e=%0d: got ph=%0d bf=%0b want %0d", e, b_ph, b_bf, e % 2);
            end
        end
        b_v = 1'b0; b_r = '0; b_i = '0;
        @(posedge clk); #1;
        total++;
        if (b_ov !== 1'b0 || b_dr !== 16'sd0) begin
            bad++; $display("FAIL d1_stop: got v=%0b r=%h want 0 0", b_ov, b_dr);
        end
        waited = 0;
        while (b_busy === 1'b1 && waited < 4) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (b_busy !== 1'b0 || b_ph !== 1'b0 || b_ov !== 1'b0) begin
            bad++; $display("FAIL d1_idle: got busy=%0b ph=%0d v=%0b want 0 0 0", b_busy, b_ph, b_ov);
        end
    endtask

    // DEPTH=32, 70% random input density against a slot-array model
    task automatic test_random_d32();
        bit          mv [32];
        logic [23:0] mr [32];
        logic [23:0] mi [32];
        int          mph;
        bit          iv, any, post_any;
        logic [23:0] rr, ri;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            mv[k] = 1'b0; mr[k] = '0; mi[k] = '0;
        end
        mph = 0;
        for (int cyc = 0; cyc < 760; cyc++) begin
            iv = (cyc < 680) && ($urandom_range(0, 99) < 70);
            rr = 24'($urandom);
            ri = 24'($urandom);
            c_v = iv; c_r = iv ? rr : '0; c_i = iv ? ri : '0;
            any = 1'b0;
            for (int k = 0; k < 32; k++) any |= mv[k];
            if (iv || any) begin
                for (int k = 31; k > 0; k--) begin
                    mv[k] = mv[k-1]; mr[k] = mr[k-1]; mi[k] = mi[k-1];
                end
                mv[0] = iv; mr[0] = iv ? rr : '0; mi[0] = iv ? ri : '0;
                post_any = 1'b0;
                for (int k = 0; k < 32; k++) post_any |= mv[k];
                mph = (!iv && !post_any) ? 0 : (mph + 1) % 64;
            end else begin
                post_any = 1'b0;
            end
            @(posedge clk); #1;
            total++;
            if (c_ov !== mv[31] || c_dr !== mr[31] || c_di !== mi[31]) begin
                bad++; $display("FAIL rnd_data cyc=%0d: got v=%0b r=%h i=%h want v=%0b r=%h i=%h", cyc, c_ov, c_dr, c_di,
                                mv[31], mr[31], mi[31]);
            end
            total++;
            if (c_ph !== 6'(mph) || c_bf !== (mph >= 32) || c_busy !== post_any) begin
                bad++; $display("FAIL rnd_ctrl cyc=%0d: got ph=%0d bf=%0b busy=%0b want ph=%0d bf=%0b busy=%0b", cyc,
                                c_ph, c_bf, c_busy, mph, (mph >= 32), post_any);
            end
        end
        c_v = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_drain();
        test_gap();
        test_async_reset();
        test_depth1();
        test_random_d32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
